// File: rtl/cs_decode_gen2.sv
// cs_decode_gen2: registered chip-select decoder for the 68HC000 bus.
// The selects are latched when a bus cycle starts, held while BACT stays high,
// and cleared on the first edge that samples BACT low.
// The block also runs the boot-ROM overlay FSM, a retriggerable I/O QoS window
// and a credit pool for posted video-RAM writes.
// Optional feature: define CS_SNDQOS_EN to decode sound-buffer writes (SndQoSCS).
// A sound-buffer write also retriggers the QoS window.
module cs_decode_gen2 #(
    parameter int         AW        = 24,
    parameter logic [7:0] VRAM_PAGE = 8'h3F,
    parameter int         QOS_HOLD  = 16,
    parameter int         PW_DEPTH  = 2
) (
    input  logic          CLK,
    input  logic          nRES,
    input  logic [AW-1:8] A,
    input  logic          nWE,
    input  logic          BACT,
    input  logic          IOQoSEN,
    input  logic          PWDone,
    output logic          IOCS,
    output logic          IORealCS,
    output logic          IOPWCS,
    output logic          IACS,
    output logic          ROMCS,
    output logic          ROMCS4X,
    output logic          RAMCS,
    output logic          RAMCS0X,
    output logic          IOQoSCS,
    output logic          SndQoSCS,
    output logic          QoSActive,
    output logic          PWFull,
    output logic          OverlayOut
);

    localparam int QW = (QOS_HOLD > 0) ? $clog2(QOS_HOLD + 1) : 1;

    typedef enum logic [1:0] {OVL_ON, OVL_ARM, OVL_OFF} ovl_t;

    typedef struct packed {
        logic io;
        logic io_real;
        logic io_pw;
        logic ia;
        logic rom;
        logic rom4x;
        logic ram;
        logic ram0x;
        logic io_qos;
        logic snd_qos;
    } sel_t;

    ovl_t        ovl_st, ovl_nxt;
    sel_t        dec, sel;
    logic        bact_q;
    logic [3:0]  pwcnt;
    logic [QW-1:0] qcnt;
    logic [3:0]  region;
    logic        vw, start, overlay, snd_hit, pw_inc;

    assign region  = A[AW-1:AW-4];
    assign vw      = (A[AW-1:AW-8] == VRAM_PAGE) && !nWE;
    assign start   = BACT && !bact_q;
    assign overlay = (ovl_st != OVL_OFF);
    assign pw_inc  = start && dec.io_pw;

`ifdef CS_SNDQOS_EN
    assign snd_hit = vw && (((A[15:12] == 4'hF) && (A[11:8] inside {4'hD, 4'hE, 4'hF})) ||
                            ((A[15:12] == 4'hA) && (A[11:8] inside {4'h1, 4'h2, 4'h3})));
`else
    assign snd_hit = 1'b0;
    logic unused_a;
    assign unused_a = ^A[AW-9:8];
`endif

    // Combinational select decode, sampled into sel only on a cycle start
    always_comb begin
        dec         = '0;
        dec.ia      = (region == 4'hF);
        dec.io_qos  = region inside {4'hF, 4'hE, 4'hD, 4'hB, 4'h9, 4'h5};
        dec.io_real = (region >= 4'h5);
        dec.rom4x   = (region == 4'h4);
        dec.ram0x   = (region[3:2] == 2'b00);
        dec.rom     = overlay || dec.rom4x;
        dec.ram     = dec.ram0x && !overlay;
        dec.io_pw   = vw && !IOQoSEN && (pwcnt < 4'(PW_DEPTH));
        dec.snd_qos = snd_hit;
        // a VRAM write without a free credit takes the synchronous IOB path
        dec.io      = dec.io_real || IOQoSEN || (vw && !dec.io_pw);
    end

    // Previous BACT sample for cycle-start detection
    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) bact_q <= 1'b0;
        else       bact_q <= BACT;
    end

    // Select latch: capture on start, hold through the cycle, clear when BACT drops
    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES)      sel <= '0;
        else if (!BACT) sel <= '0;
        else if (start) sel <= dec;
    end

    // Overlay FSM state register
    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) ovl_st <= OVL_ON;
        else       ovl_st <= ovl_nxt;
    end

    // Overlay next state: first 4X ROM cycle arms, end of that cycle disarms for good
    always_comb begin
        ovl_nxt = ovl_st;
        case (ovl_st)
            OVL_ON:  if (start && dec.rom4x) ovl_nxt = OVL_ARM;
            OVL_ARM: if (!BACT)              ovl_nxt = OVL_OFF;
            OVL_OFF: ovl_nxt = OVL_OFF;
            default: ovl_nxt = OVL_ON;
        endcase
    end

    // Posted-write credit counter; a grant and a retire on one edge cancel out
    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES)                         pwcnt <= 4'd0;
        else if (pw_inc && PWDone)         pwcnt <= pwcnt;
        else if (pw_inc)                   pwcnt <= pwcnt + 4'd1;
        else if (PWDone && pwcnt != 4'd0)  pwcnt <= pwcnt - 4'd1;
    end

    // QoS window timer: retriggered by every QoS-class access, else counts down to 0
    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES)                                  qcnt <= '0;
        else if (start && (dec.io_qos || snd_hit))  qcnt <= QW'(QOS_HOLD);
        else if (qcnt != '0)                        qcnt <= qcnt - QW'(1);
    end

    assign IOCS       = sel.io;
    assign IORealCS   = sel.io_real;
    assign IOPWCS     = sel.io_pw;
    assign IACS       = sel.ia;
    assign ROMCS      = sel.rom;
    assign ROMCS4X    = sel.rom4x;
    assign RAMCS      = sel.ram;
    assign RAMCS0X    = sel.ram0x;
    assign IOQoSCS    = sel.io_qos;
    assign SndQoSCS   = sel.snd_qos;
    assign QoSActive  = (qcnt != '0);
    assign PWFull     = (pwcnt == 4'(PW_DEPTH));
    assign OverlayOut = overlay;

endmodule

// File: doc/cs_decode_gen2.md
# cs_decode_gen2

Registered, parametrised chip-select decoder for the 68HC000 bus: latches device selects at the start of each bus cycle and holds them for its duration. Sequences the boot ROM overlay with an explicit state machine. Generates a timed I/O QoS window and manages a bounded pool of posted video-RAM write credits. Sits between the CPU address/strobe logic and the IOB / RAM / ROM controllers, replacing the purely combinational select path.

## Interface
Parameters:
- AW, 24: CPU address width; bits A[AW-1:8] are decoded; region nibble is A[AW-1:AW-4].
- VRAM_PAGE, 8'h3F: value of A[AW-1:AW-8] selecting the 64 KiB video/sound page.
- QOS_HOLD, 16: cycles the QoS window stays active after an I/O access; 0 disables the window.
- PW_DEPTH, 2: maximum outstanding posted writes (1..15).

Ports:
- CLK  in  1  system clock; all state on rising edge.
- nRES  in  1  reset, asynchronous, active-low.
- A  in  AW-8  address bits A[AW-1:8].
- nWE  in  1  write strobe, low = write.
- BACT  in  1  bus cycle active.
- IOQoSEN  in  1  force all accesses onto the IOB path.
- PWDone  in  1  one-cycle pulse: one posted write retired downstream.
- IOCS, IORealCS, IOPWCS, IACS, ROMCS, ROMCS4X, RAMCS, RAMCS0X, IOQoSCS, SndQoSCS  out  1 each  latched selects.
- QoSActive  out  1  QoS window active.
- PWFull  out  1  posted-write credits exhausted.
- OverlayOut  out  1  overlay state is OVL_ON or OVL_ARM.

## Operation
- Region nibble R = A[AW-1:AW-4]. IACS: R=F. IOQoSCS: R in {F,E,D,B,9,5}. IORealCS: R in 5..F except 4. ROMCS4X: R=4. RAMCS0X: top two bits 00. VRAM write (VW): page match and nWE=0.
- Overlay FSM, states OVL_ON (reset) -> OVL_ARM -> OVL_OFF.
  - OVL_ON -> OVL_ARM on a cycle start with ROMCS4X.
  - OVL_ARM -> OVL_OFF on the edge BACT is sampled low.
  - OVL_OFF is terminal until reset.
- ROMCS = overlay || ROMCS4X. RAMCS = RAMCS0X && !overlay. Both are evaluated with the FSM state before the cycle-start edge.
- Posted writes, 4-bit credit counter PWCNT:
  - IOPWCS = VW && !IOQoSEN && PWCNT<PW_DEPTH. On IOPWCS latch, PWCNT increments.
  - PWDone decrements PWCNT. PWDone at PWCNT=0 is ignored.
  - Latch and PWDone on the same edge leave PWCNT unchanged.
  - PWFull = (PWCNT==PW_DEPTH).
- IOCS = IORealCS || IOQoSEN || (VW && !IOPWCS). A VRAM write with no credit falls back to the synchronous IOB path.
- QoS counter, QCNT:
  - Loads QOS_HOLD on a cycle start with IOQoSCS; a reload occurs even if QCNT is already nonzero.
  - Otherwise QCNT decrements to 0 and saturates there.
  - QoSActive = QCNT!=0.

## Timing
- Cycle start = BACT=1 sampled on an edge where the registered previous BACT was 0.
- All selects are registered on the cycle-start edge and valid from the following cycle, i.e. 1 CLK latency.
- Selects hold constant while BACT=1, ignoring A changes.
- Selects clear on the first edge BACT is sampled 0.
- Back-to-back cycles need at least one BACT-low sample between them; BACT held high never re-latches.
- Reset values: all select outputs 0, QoSActive 0, PWFull 0, OverlayOut 1, PWCNT 0, QCNT 0, FSM OVL_ON.
- Asserting nRES mid-cycle clears everything immediately, including outstanding credits, and restores the overlay.

## Configuration
- CS_SNDQOS_EN defined:
  - SndQoSCS = VW and (A[15:12]=F with A[11:8] in {D,E,F}, or A[15:12]=A with A[11:8] in {1,2,3}).
  - A sound-buffer write also loads QCNT.
- CS_SNDQOS_EN undefined: SndQoSCS tied 0 and sound writes do not affect QCNT.

## Test plan
- Reset, then read A=0x000000 -> ROMCS=1, RAMCS=0, OverlayOut=1. Then a cycle at 0x400000 -> OverlayOut=0 after BACT falls. Next 0x000000 read -> RAMCS=1, ROMCS=0.
- PW_DEPTH=2: three VRAM writes to 0x3F2000, no PWDone -> IOPWCS 1,1,0, third has IOCS=1, PWFull=1. Then one PWDone -> PWFull=0.
- PWDone coincident with a posted-write latch at PWCNT=1 -> PWCNT stays 1. PWDone at PWCNT=0 -> no underflow.
- Read 0xE00000 with QOS_HOLD=16 -> IOQoSCS=1, QoSActive high 16 cycles. A second VIA access at cycle 10 -> window extends to 16 cycles from the second access.
- A changes while BACT held high -> selects unchanged. nRES pulse mid-cycle -> all outputs at reset values in the same cycle.
- With CS_SNDQOS_EN, a write to 0x3FFD00 -> SndQoSCS=1 and QoSActive=1. Without the macro -> SndQoSCS=0.
